wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register and write-back stage of the RISC-V core. Captures
//  one retiring instruction per cycle, selects and extends the result, and
//  drives the register file write port (A3/WD3/WE).
//  Also exports a same-cycle bypass for decode-stage reads, flags load-alignment
//  faults, and counts retired instructions.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported (RV32I)
//  CNT_W     32  width of the INSTRET counter
// PORTS
//  CLK         in   1     clock; all state updates on posedge
//  RST         in   1     asynchronous reset, active-high
//  STALL       in   1     hold the current WB entry; no capture
//  FLUSH       in   1     capture a bubble instead of the inputs
//  IN_VALID    in   1     upstream holds a valid instruction
//  REG_WRITE   in   1     instruction writes rd
//  RD_ADDR     in   5     destination register
//  RESULT_SRC  in   2     00 ALU, 01 load, 10 PC+4, 11 IMM (LUI)
//  ALU_RESULT  in   32    ALU output; bits [1:0] are also the load address LSBs
//  READ_DATA   in   32    raw aligned data-memory word
//  PC_PLUS4    in   32    link value for JAL/JALR
//  IMM_EXT     in   32    extended immediate
//  LOAD_F3     in   3     funct3 of the load (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//  A3          out  5     regfile write address
//  WD3         out  32    regfile write data
//  WE          out  1     regfile write enable
//  FWD_VALID   out  1     bypass valid (== WE)
//  FWD_ADDR    out  5     bypass register (== A3)
//  FWD_DATA    out  32    bypass data (== WD3)
//  LOAD_ERR    out  1     faulting load in WB (misaligned or illegal funct3)
//  INSTRET     out  CNT_W retired-instruction count
// BEHAVIOUR
//  - Reset: valid_q=0, all captured fields 0, INSTRET=0. Consequently WE=0,
//    A3=0, WD3=0, FWD_*=0 and LOAD_ERR=0 while RST is high and after release.
//  - Capture at each posedge, with priority FLUSH > STALL > load:
//    - FLUSH: valid_q<=0.
//    - STALL: hold all fields.
//    - Otherwise: load all inputs; valid_q<=IN_VALID.
//  - Latency: inputs captured at edge N drive A3/WD3/WE during cycle N+1.
//    The regfile writes at edge N+1. All outputs are combinational from registers.
//  - Result mux: ALU_RESULT, extended load, PC_PLUS4 or IMM_EXT, per RESULT_SRC.
//  - Load extension uses lsb = ALU_RESULT[1:0]:
//    - LB/LBU: byte READ_DATA[8*lsb +: 8], sign-/zero-extended.
//    - LH/LHU: half READ_DATA[16*lsb[1] +: 16], sign-/zero-extended.
//    - LW: full word.
//  - LOAD_ERR = valid_q & RESULT_SRC==01 & one of:
//    - LH/LHU with lsb[0]=1;
//    - LW with lsb!=0;
//    - LOAD_F3 in {011,110,111}.
//  - WE = valid_q & REG_WRITE & (RD_ADDR!=0) & ~LOAD_ERR. Writes to x0 are
//    never issued; A3/WD3 are still driven from the captured values.
//  - WE stays high for every cycle the stage is stalled. A repeated write is
//    idempotent and permitted.
//  - Bypass: FWD_* mirror WE/A3/WD3 exactly. Decode selects FWD_DATA when
//    FWD_VALID & FWD_ADDR==source register, covering the same-cycle RAW hole.
//  - INSTRET increments by 1 (modulo 2^CNT_W, wraps silently) at each edge with
//    valid_q=1, STALL=0 and LOAD_ERR=0.
//    - FLUSH at that edge still counts the departing entry; FLUSH kills only
//      the incoming one.
//  - RST asserted mid-stall or mid-flush: immediate clear; no write is issued
//    after RST rises.
// TESTING
//  1. RST pulse, then IN_VALID=1, REG_WRITE=1, RD=5, SRC=00, ALU=0x1234 -> next
//     cycle WE=1, A3=5, WD3=0x1234; INSTRET 0->1 at the following edge.
//  2. LB, READ_DATA=0x80FF7F01, ALU[1:0]=3 -> WD3=0xFFFFFF80.
//     Same input with LBU -> WD3=0x00000080.
//     Same input with LHU, ALU[1:0]=2 -> WD3=0x000080FF.
//  3. LW with ALU[1:0]=2 -> LOAD_ERR=1, WE=0, INSTRET unchanged.
//     LOAD_F3=011 -> LOAD_ERR=1.
//  4. RD=0, REG_WRITE=1, SRC=10, PC+4=0x104 -> WE=0, INSTRET still increments.
//  5. STALL=1 for 3 cycles with an entry in WB -> A3/WD3/WE unchanged,
//     INSTRET unchanged until STALL drops, then +1.
//     FLUSH and STALL together -> bubble (WE=0 next cycle).
//  6. Preload INSTRET to 0xFFFFFFFF via retirements/force, retire once -> 0.
//     Assert RST mid-stream -> WE=0 on the same cycle, INSTRET=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bus: the retiring-instruction fields in, the regfile write port,
// the decode bypass, the load fault flag and the retire counter out.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             STALL;
  logic             FLUSH;
  logic             IN_VALID;
  logic             REG_WRITE;
  logic [4:0]       RD_ADDR;
  logic [1:0]       RESULT_SRC;
  logic [XLEN-1:0]  ALU_RESULT;
  logic [XLEN-1:0]  READ_DATA;
  logic [XLEN-1:0]  PC_PLUS4;
  logic [XLEN-1:0]  IMM_EXT;
  logic [2:0]       LOAD_F3;

  logic [4:0]       A3;
  logic [XLEN-1:0]  WD3;
  logic             WE;
  logic             FWD_VALID;
  logic [4:0]       FWD_ADDR;
  logic [XLEN-1:0]  FWD_DATA;
  logic             LOAD_ERR;
  logic [CNT_W-1:0] INSTRET;

  modport master (
    output STALL, FLUSH, IN_VALID, REG_WRITE, RD_ADDR, RESULT_SRC,
           ALU_RESULT, READ_DATA, PC_PLUS4, IMM_EXT, LOAD_F3,
    input  A3, WD3, WE, FWD_VALID, FWD_ADDR, FWD_DATA, LOAD_ERR, INSTRET
  );

  modport slave (
    input  STALL, FLUSH, IN_VALID, REG_WRITE, RD_ADDR, RESULT_SRC,
           ALU_RESULT, READ_DATA, PC_PLUS4, IMM_EXT, LOAD_F3,
    output A3, WD3, WE, FWD_VALID, FWD_ADDR, FWD_DATA, LOAD_ERR, INSTRET
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: result select, load extension,
// regfile write port with same-cycle bypass, load fault detection, INSTRET.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic      CLK,
  input  logic      RST,
  wb_stage_if.slave wb
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Pick the addressed byte/half out of the aligned word and extend it.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                  input logic [1:0]      lsb,
                                                  input logic [XLEN-1:0] word);
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] r;
    b = word[8*lsb +: 8];
    h = word[16*lsb[1] +: 16];
    case (f3)
      F3_LB:   r = XLEN'(b);
      F3_LBU:  r = XLEN'($unsigned(b));
      F3_LH:   r = XLEN'(h);
      F3_LHU:  r = XLEN'($unsigned(h));
      default: r = word;
    endcase
    return $unsigned(r);
  endfunction

  function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] lsb);
    logic f;
    case (f3)
      F3_LB, F3_LBU: f = 1'b0;
      F3_LH, F3_LHU: f = lsb[0];
      F3_LW:         f = (lsb != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

  logic             vld_p1;
  logic             reg_write_p1;
  logic [4:0]       rd_p1;
  logic [1:0]       src_p1;
  logic [XLEN-1:0]  alu_p1;
  logic [XLEN-1:0]  rdata_p1;
  logic [XLEN-1:0]  pc4_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [2:0]       f3_p1;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0]  result;
  logic             load_err;
  logic             we;

  // ---- MEM -> WB boundary: FLUSH beats STALL beats capture ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      rd_p1        <= '0;
      src_p1       <= '0;
      alu_p1       <= '0;
      rdata_p1     <= '0;
      pc4_p1       <= '0;
      imm_p1       <= '0;
      f3_p1        <= '0;
    end else if (wb.FLUSH) begin
      vld_p1       <= 1'b0;
    end else if (!wb.STALL) begin
      vld_p1       <= wb.IN_VALID;
      reg_write_p1 <= wb.REG_WRITE;
      rd_p1        <= wb.RD_ADDR;
      src_p1       <= wb.RESULT_SRC;
      alu_p1       <= wb.ALU_RESULT;
      rdata_p1     <= wb.READ_DATA;
      pc4_p1       <= wb.PC_PLUS4;
      imm_p1       <= wb.IMM_EXT;
      f3_p1        <= wb.LOAD_F3;
    end
  end

  // ---- WB: result select, fault check, write enable ----
  always_comb begin
    result = imm_p1;
    case (src_p1)
      SRC_ALU:  result = alu_p1;
      SRC_LOAD: result = load_extend(f3_p1, alu_p1[1:0], rdata_p1);
      SRC_PC4:  result = pc4_p1;
      default:  result = imm_p1;
    endcase
  end

  always_comb begin
    load_err = vld_p1 && (src_p1 == SRC_LOAD) && load_fault(f3_p1, alu_p1[1:0]);
    we       = vld_p1 && reg_write_p1 && (rd_p1 != 5'd0) && !load_err;
  end

  // A stalled entry does not retire yet; a flushed-over entry departs and does.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instret_q <= '0;
    end else if (vld_p1 && !wb.STALL && !load_err) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign wb.A3        = rd_p1;
  assign wb.WD3       = result;
  assign wb.WE        = we;
  assign wb.FWD_VALID = we;
  assign wb.FWD_ADDR  = rd_p1;
  assign wb.FWD_DATA  = result;
  assign wb.LOAD_ERR  = load_err;
  assign wb.INSTRET   = instret_q;

endmodule
